// File: rtl/mcp_bmp_ctrl.sv
// mcp_bmp_ctrl: FX-BMP backup-memory controller on the Memory Card Port.
// Decodes the BMP window, runs one registered bus cycle per MCP strobe
// toward a req/ack save-RAM arbiter and serves the battery-status window.
// Also provides write protect, a dirty flag for save flushing and an ack timeout.
//
// Ports:
//   CLK, RESn              clock, asynchronous active-low reset
//   CFG_EN/SIZE/WP         BMP present, RAM size code, write protect
//   BAT_LOW                battery bad indication for the status window
//   MCP_A/DI/DO            MCP address A[26:1], write data, registered read data
//   MCP_CSn/RDn/WRn        MCP cart select and strobes
//   MCP_READYn             low = cycle complete, held until strobes release
//   RAM_A/DI/DO            masked RAM address, RAM write data, RAM read data
//   RAM_REQ/WE/ACK         request (held until ack or abort), direction, ack pulse
//   DIRTY, DIRTY_CLR       SRAM modified flag and its clear
//   TO_ERR                 sticky RAM access timeout flag
module mcp_bmp_ctrl #(
    parameter int unsigned RAM_AW  = 23,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              CLK,
    input  logic              RESn,
    input  logic              CFG_EN,
    input  logic [2:0]        CFG_SIZE,
    input  logic              CFG_WP,
    input  logic              BAT_LOW,
    input  logic [25:0]       MCP_A,
    input  logic [7:0]        MCP_DI,
    output logic [7:0]        MCP_DO,
    input  logic              MCP_CSn,
    input  logic              MCP_RDn,
    input  logic              MCP_WRn,
    output logic              MCP_READYn,
    output logic [RAM_AW-1:0] RAM_A,
    output logic [7:0]        RAM_DI,
    input  logic [7:0]        RAM_DO,
    output logic              RAM_REQ,
    output logic              RAM_WE,
    input  logic              RAM_ACK,
    output logic              DIRTY,
    input  logic              DIRTY_CLR,
    output logic              TO_ERR
);

    typedef enum logic [1:0] {
        IDLE,
        REQ_WAIT,
        DONE
    } state_t;

    localparam logic [15:0] TO_VAL = 16'(TIMEOUT);

    state_t            state;
    logic [15:0]       cnt;
    logic              start;
    logic              wr_req;
    logic              bmp_sel;
    logic              sram_sel;
    logic              bat_sel;
    logic              released;
    logic [RAM_AW-1:0] mask;

    // Address bits above the RAM window never reach the RAM side.
    logic unused;
    assign unused = ^MCP_A;

    // MCP_A[i] carries byte address bit A[i+1].
    always_comb begin
        start    = ~MCP_CSn & (~MCP_RDn | ~MCP_WRn);
        wr_req   = ~MCP_WRn;
        bmp_sel  = CFG_EN & ~MCP_A[25];
        sram_sel = bmp_sel & ~MCP_A[24];
        bat_sel  = bmp_sel & MCP_A[24];
        released = MCP_CSn | (MCP_RDn & MCP_WRn);
    end

    // 128KB always mapped; each size step opens one more bit, up to bit 22.
    always_comb begin
        mask = '0;
        for (int unsigned i = 0; i < RAM_AW; i++) begin
            mask[i] = (i < 17) || ((i <= 22) && ((i - 16) <= 32'(CFG_SIZE)));
        end
    end

    always_ff @(posedge CLK or negedge RESn) begin
        if (!RESn) begin
            state      <= IDLE;
            cnt        <= '0;
            MCP_DO     <= '1;
            MCP_READYn <= 1'b1;
            RAM_REQ    <= 1'b0;
            RAM_WE     <= 1'b0;
            RAM_A      <= '0;
            RAM_DI     <= '0;
            DIRTY      <= 1'b0;
            TO_ERR     <= 1'b0;
        end else begin
            // A write ack later in this block overrides the clear.
            if (DIRTY_CLR) DIRTY <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (sram_sel && !(wr_req && CFG_WP)) begin
                            RAM_REQ <= 1'b1;
                            RAM_WE  <= wr_req;
                            RAM_A   <= MCP_A[RAM_AW-1:0] & mask;
                            RAM_DI  <= MCP_DI;
                            cnt     <= '0;
                            state   <= REQ_WAIT;
                        end else begin
                            MCP_DO <= bat_sel ? {7'h7F, ~BAT_LOW} : 8'hFF;
                            state  <= DONE;
                        end
                    end
                end
                REQ_WAIT: begin
                    cnt <= cnt + 16'd1;
                    // An ack on the expiry cycle still completes normally.
                    if (RAM_ACK) begin
                        RAM_REQ    <= 1'b0;
                        MCP_READYn <= 1'b0;
                        state      <= DONE;
                        if (RAM_WE) DIRTY  <= 1'b1;
                        else        MCP_DO <= RAM_DO;
                    end else if (cnt + 16'd1 >= TO_VAL) begin
                        RAM_REQ    <= 1'b0;
                        MCP_READYn <= 1'b0;
                        MCP_DO     <= 8'hFF;
                        TO_ERR     <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    // Strobes already gone after a RAM access give a one-cycle READYn pulse.
                    if (released) begin
                        MCP_READYn <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        MCP_READYn <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mcp_bmp_ctrl.sv
// tb_mcp_bmp_ctrl: directed bench for mcp_bmp_ctrl with a transaction-level
// expectation model and a per-cycle output compare.
module tb_mcp_bmp_ctrl;

    localparam int TO = 4;

    logic        CLK = 1'b0;
    logic        RESn = 1'b0;
    logic        CFG_EN = 1'b1;
    logic [2:0]  CFG_SIZE = 3'd0;
    logic        CFG_WP = 1'b0;
    logic        BAT_LOW = 1'b0;
    logic [25:0] MCP_A = '0;
    logic [7:0]  MCP_DI = '0;
    logic [7:0]  MCP_DO;
    logic        MCP_CSn = 1'b1;
    logic        MCP_RDn = 1'b1;
    logic        MCP_WRn = 1'b1;
    logic        MCP_READYn;
    logic [22:0] RAM_A;
    logic [7:0]  RAM_DI;
    logic [7:0]  RAM_DO = '0;
    logic        RAM_REQ;
    logic        RAM_WE;
    logic        RAM_ACK = 1'b0;
    logic        DIRTY;
    logic        DIRTY_CLR = 1'b0;
    logic        TO_ERR;

    always #5 CLK = ~CLK;

    mcp_bmp_ctrl #(.RAM_AW(23), .TIMEOUT(TO)) dut (
        .CLK(CLK), .RESn(RESn), .CFG_EN(CFG_EN), .CFG_SIZE(CFG_SIZE),
        .CFG_WP(CFG_WP), .BAT_LOW(BAT_LOW), .MCP_A(MCP_A), .MCP_DI(MCP_DI),
        .MCP_DO(MCP_DO), .MCP_CSn(MCP_CSn), .MCP_RDn(MCP_RDn), .MCP_WRn(MCP_WRn),
        .MCP_READYn(MCP_READYn), .RAM_A(RAM_A), .RAM_DI(RAM_DI), .RAM_DO(RAM_DO),
        .RAM_REQ(RAM_REQ), .RAM_WE(RAM_WE), .RAM_ACK(RAM_ACK), .DIRTY(DIRTY),
        .DIRTY_CLR(DIRTY_CLR), .TO_ERR(TO_ERR)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Expected outputs after the next rising edge.
    logic [7:0]  exp_do = 8'hFF;
    logic        exp_readyn = 1'b1;
    logic        exp_req = 1'b0;
    logic [22:0] exp_a = '0;
    logic        exp_we = 1'b0;
    logic [7:0]  exp_di = '0;
    logic        exp_dirty = 1'b0;
    logic        exp_toerr = 1'b0;
    bit          chk_en = 1'b0;

    // Observations gathered by the monitor.
    int          req_len = 0;
    int          rdy_len = 0;
    logic [22:0] last_a = '0;
    logic        last_we = 1'b0;
    logic [7:0]  last_di = '0;
    logic        prev_req = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
        end
    endtask

    function automatic logic [22:0] model_a(input logic [25:0] a, input logic [2:0] sz);
        int s;
        s = (sz > 3'd6) ? 6 : int'(sz);
        return 23'(a & ((26'd1 << (17 + s)) - 26'd1));
    endfunction

    always begin
        @(posedge CLK);
        #1;
        if (chk_en) begin
            chk("MCP_DO", 32'(MCP_DO), 32'(exp_do));
            chk("MCP_READYn", 32'(MCP_READYn), 32'(exp_readyn));
            chk("RAM_REQ", 32'(RAM_REQ), 32'(exp_req));
            chk("DIRTY", 32'(DIRTY), 32'(exp_dirty));
            chk("TO_ERR", 32'(TO_ERR), 32'(exp_toerr));
            if (exp_req) begin
                chk("RAM_A", 32'(RAM_A), 32'(exp_a));
                chk("RAM_WE", 32'(RAM_WE), 32'(exp_we));
                chk("RAM_DI", 32'(RAM_DI), 32'(exp_di));
            end
        end
        if (RAM_REQ) begin
            req_len = prev_req ? req_len + 1 : 1;
            last_a  = RAM_A;
            last_we = RAM_WE;
            last_di = RAM_DI;
        end
        prev_req = RAM_REQ;
        if (!MCP_READYn) rdy_len++;
    end

    // One MCP bus cycle. ack_n = edge index after the start edge at which
    // RAM_ACK is sampled (0 = never).
    task automatic xfer(input bit wr, input bit both, input logic [25:0] a,
                        input logic [7:0] di, input int ack_n, input logic [7:0] rdata,
                        input bit clr_at_ack, input bit early_rel);
        bit bmp, sram, bat, ram;
        @(negedge CLK);
        req_len = 0;
        rdy_len = 0;
        MCP_CSn = 1'b0;
        MCP_A   = a;
        MCP_DI  = di;
        MCP_WRn = !wr;
        MCP_RDn = wr && !both;
        bmp  = CFG_EN && !a[25];
        sram = bmp && !a[24];
        bat  = bmp && a[24];
        ram  = sram && !(wr && CFG_WP);
        if (ram) begin
            exp_req = 1'b1;
            exp_a   = model_a(a, CFG_SIZE);
            exp_we  = wr;
            exp_di  = di;
        end else begin
            exp_do = bat ? {7'h7F, ~BAT_LOW} : 8'hFF;
        end
        @(negedge CLK);
        if (ram) begin
            for (int n = 1; n <= TO; n++) begin
                if (early_rel && n == 1) begin
                    MCP_CSn = 1'b1; MCP_RDn = 1'b1; MCP_WRn = 1'b1;
                end
                if (n == ack_n) begin
                    RAM_ACK    = 1'b1;
                    RAM_DO     = rdata;
                    DIRTY_CLR  = clr_at_ack;
                    exp_req    = 1'b0;
                    exp_readyn = 1'b0;
                    if (wr) exp_dirty = 1'b1;
                    else    exp_do = rdata;
                end else if (n == TO) begin
                    exp_req    = 1'b0;
                    exp_readyn = 1'b0;
                    exp_do     = 8'hFF;
                    exp_toerr  = 1'b1;
                end
                @(negedge CLK);
                RAM_ACK   = 1'b0;
                DIRTY_CLR = 1'b0;
                if (!exp_req) break;
            end
        end else begin
            exp_readyn = 1'b0;
            @(negedge CLK);
        end
        if (!early_rel) begin
            @(negedge CLK);
            MCP_CSn = 1'b1; MCP_RDn = 1'b1; MCP_WRn = 1'b1;
        end
        exp_readyn = 1'b1;
        @(negedge CLK);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge CLK);
        chk("rst_DO", 32'(MCP_DO), 32'hFF);
        chk("rst_READYn", 32'(MCP_READYn), 32'd1);
        chk("rst_REQ", 32'(RAM_REQ), 32'd0);
        chk("rst_WE", 32'(RAM_WE), 32'd0);
        chk("rst_A", 32'(RAM_A), 32'd0);
        chk("rst_DI", 32'(RAM_DI), 32'd0);
        chk("rst_DIRTY", 32'(DIRTY), 32'd0);
        chk("rst_TO_ERR", 32'(TO_ERR), 32'd0);
        RESn   = 1'b1;
        chk_en = 1'b1;

        // SRAM write, ack on the third wait edge.
        xfer(1, 0, 26'h000_0100, 8'h5A, 3, 8'h00, 0, 0);
        chk("wr_a", 32'(last_a), 32'h100);
        chk("wr_we", 32'(last_we), 32'd1);
        chk("wr_di", 32'(last_di), 32'h5A);
        chk("wr_req_len", 32'(req_len), 32'd3);
        chk("wr_rdy_len", 32'(rdy_len), 32'd2);
        chk("wr_dirty", 32'(DIRTY), 32'd1);

        @(negedge CLK);
        DIRTY_CLR = 1'b1;
        exp_dirty = 1'b0;
        @(negedge CLK);
        DIRTY_CLR = 1'b0;
        chk("clr_dirty", 32'(DIRTY), 32'd0);

        // Size masking.
        xfer(0, 0, 26'h003_0000, 8'h00, 2, 8'h3C, 0, 0);
        chk("sz0_a", 32'(last_a), 32'h1_0000);
        chk("sz0_do", 32'(MCP_DO), 32'h3C);
        CFG_SIZE = 3'd6;
        xfer(0, 0, 26'h003_0000, 8'h00, 1, 8'hC3, 0, 0);
        chk("sz6_a", 32'(last_a), 32'h3_0000);
        CFG_SIZE = 3'd3;
        xfer(0, 0, 26'h03F_FFFF, 8'h00, 1, 8'h11, 0, 0);
        chk("sz3_a", 32'(last_a), 32'hF_FFFF);
        CFG_SIZE = 3'd7;
        xfer(0, 0, 26'h0FF_FFFF, 8'h00, 2, 8'h22, 0, 0);
        chk("sz7_a", 32'(last_a), 32'h7F_FFFF);

        // Battery window and unselected space.
        xfer(0, 0, 26'h100_0000, 8'h00, 0, 8'h00, 0, 0);
        chk("bat_ok_do", 32'(MCP_DO), 32'hFF);
        chk("bat_no_req", 32'(req_len), 32'd0);
        BAT_LOW = 1'b1;
        xfer(0, 0, 26'h100_0004, 8'h00, 0, 8'h00, 0, 0);
        chk("bat_low_do", 32'(MCP_DO), 32'hFE);
        chk("bat_rdy_len", 32'(rdy_len), 32'd2);
        xfer(1, 0, 26'h100_0000, 8'h77, 0, 8'h00, 0, 0);
        chk("bat_wr_dirty", 32'(DIRTY), 32'd0);
        xfer(0, 0, 26'h200_0100, 8'h00, 0, 8'h00, 0, 0);
        chk("unsel_do", 32'(MCP_DO), 32'hFF);
        CFG_EN = 1'b0;
        xfer(0, 0, 26'h000_0100, 8'h00, 0, 8'h00, 0, 0);
        chk("dis_no_req", 32'(req_len), 32'd0);
        CFG_EN = 1'b1;

        // Write protect: write acknowledged without RAM access; reads still work.
        CFG_WP = 1'b1;
        xfer(1, 0, 26'h000_0200, 8'h33, 0, 8'h00, 0, 0);
        chk("wp_no_req", 32'(req_len), 32'd0);
        chk("wp_dirty", 32'(DIRTY), 32'd0);
        xfer(0, 0, 26'h000_0200, 8'h00, 1, 8'h44, 0, 0);
        chk("wp_rd_do", 32'(MCP_DO), 32'h44);
        CFG_WP = 1'b0;

        // Both strobes low: write wins.
        xfer(1, 1, 26'h000_0300, 8'hA5, 1, 8'h00, 0, 0);
        chk("both_we", 32'(last_we), 32'd1);
        chk("both_dirty", 32'(DIRTY), 32'd1);
        @(negedge CLK);
        DIRTY_CLR = 1'b1;
        exp_dirty = 1'b0;
        @(negedge CLK);
        DIRTY_CLR = 1'b0;

        // Timeout, then clear coincident with a write ack.
        xfer(0, 0, 26'h000_0400, 8'h00, 0, 8'h00, 0, 0);
        chk("to_req_len", 32'(req_len), 32'd4);
        chk("to_do", 32'(MCP_DO), 32'hFF);
        chk("to_err", 32'(TO_ERR), 32'd1);
        xfer(1, 0, 26'h000_0500, 8'h66, 2, 8'h00, 1, 0);
        chk("clr_vs_set", 32'(DIRTY), 32'd1);

        // Ack on the expiry edge succeeds.
        xfer(0, 0, 26'h000_0600, 8'h00, TO, 8'h77, 0, 0);
        chk("edge_ack_do", 32'(MCP_DO), 32'h77);
        chk("edge_ack_len", 32'(req_len), 32'd4);

        // Strobes released during the RAM wait: access completes, READYn pulses once.
        xfer(1, 0, 26'h000_0700, 8'h88, 2, 8'h00, 0, 1);
        chk("early_len", 32'(req_len), 32'd2);
        chk("early_rdy", 32'(rdy_len), 32'd1);

        // Reset mid-access, then a late ack in IDLE.
        @(negedge CLK);
        req_len = 0;
        MCP_CSn = 1'b0; MCP_RDn = 1'b0; MCP_A = 26'h000_0040;
        exp_req = 1'b1; exp_a = 23'h40; exp_we = 1'b0; exp_di = MCP_DI;
        @(negedge CLK);
        @(negedge CLK);
        RESn = 1'b0;
        exp_req = 1'b0; exp_readyn = 1'b1; exp_do = 8'hFF;
        exp_dirty = 1'b0; exp_toerr = 1'b0;
        #1;
        chk("mid_rst_req", 32'(RAM_REQ), 32'd0);
        chk("mid_rst_ready", 32'(MCP_READYn), 32'd1);
        chk("mid_rst_toerr", 32'(TO_ERR), 32'd0);
        MCP_CSn = 1'b1; MCP_RDn = 1'b1;
        @(negedge CLK);
        RESn = 1'b1;
        @(negedge CLK);
        RAM_ACK = 1'b1; RAM_DO = 8'h99;
        @(negedge CLK);
        RAM_ACK = 1'b0;
        @(negedge CLK);
        chk("late_ack_do", 32'(MCP_DO), 32'hFF);
        chk("late_ack_ready", 32'(MCP_READYn), 32'd1);
        chk("late_ack_dirty", 32'(DIRTY), 32'd0);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
